switch_axil_slave: RTL and testbench

AXI4-Lite responder for the SMartCart switch/LED I/O path. It accepts register writes and reads from an AXI4-Lite initiator such as the lite master BFM or the PS GP port. It debounces the raw switch inputs, captures rising edges in a sticky write-1-to-clear register, and drives the LED outputs from a control register. It sits behind the interconnect as the slave endpoint at the block's base address.

---
 rtl/switch_axil_pkg.sv | 39 +++
 rtl/switch_debounce.sv | 48 ++++
 rtl/switch_axil_slave.sv | 181 ++++++++++++++++++
 tb/tb_switch_axil_slave.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_axil_pkg.sv
// ============================================================================
// Module      : switch_axil_pkg
// Description : Register offsets, response codes and byte-strobe helpers
//               shared by the switch/LED AXI4-Lite slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_axil_pkg;

    typedef enum logic [1:0] {
        REG_LED       = 2'd0,
        REG_SW_STATUS = 2'd1,
        REG_EDGE      = 2'd2,
        REG_AUX       = 2'd3    // SCRATCH, or IRQ_MASK when interrupts are built in
    } reg_word_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] mask;
        mask = strb_mask(strb);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
// Module      : switch_debounce
// Description : Single-bit switch debouncer: two-flop synchronizer, stability
//               counter and stable-level flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            cnt        <= '0;
            sw_stable  <= 1'b0;
        end else begin
            sync_meta  <= sw_raw;
            sync_level <= sync_meta;
            // Any return to the stable level restarts the qualification window.
            if (sync_level == sw_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_stable <= sync_level;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/switch_axil_slave.sv
// ============================================================================
// Module      : switch_axil_slave
// Description : AXI4-Lite slave for switch/LED I/O: debounced switch status,
//               sticky W1C rising-edge flags and LED control register.
//               Define SWITCH_IRQ_EN to add the irq output and IRQ_MASK at 0xC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_axil_slave
    import switch_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_SW             = 8,
    parameter int DEBOUNCE_CYCLES    = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,

    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,

    input  logic [NUM_SW-1:0]               sw_in,
    output logic [NUM_SW-1:0]               led_out
`ifdef SWITCH_IRQ_EN
    ,
    output logic                            irq
`endif
);

    logic                            aw_held;
    logic                            w_held;
    reg_word_e                       aw_word;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                            commit;

    logic [NUM_SW-1:0] led_reg;
    logic [NUM_SW-1:0] edge_reg;
    logic [NUM_SW-1:0] sw_stable;
    logic [NUM_SW-1:0] sw_stable_d;
    logic [NUM_SW-1:0] edge_set;
    logic [NUM_SW-1:0] edge_clr;
    logic [31:0]       aux_reg;
    logic [31:0]       led_merged;
    logic [31:0]       aux_merged;
    logic [31:0]       clr_bits;
    logic [31:0]       rd_mux;
    logic              unused_ok;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_debounce
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (ACLK),
            .rst       (ARESET),
            .sw_raw    (sw_in[i]),
            .sw_stable (sw_stable[i])
        );
    end

    // Ready signals depend only on flops, never on the incoming VALIDs.
    assign S_AXI_AWREADY = ~aw_held & ~S_AXI_BVALID;
    assign S_AXI_WREADY  = ~w_held  & ~S_AXI_BVALID;
    assign S_AXI_ARREADY = ~S_AXI_RVALID;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign led_out       = led_reg;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], led_merged, clr_bits};

    always_comb begin
        commit     = aw_held & w_held;
        led_merged = merge_wstrb(32'(led_reg), w_data, w_strb);
        aux_merged = merge_wstrb(aux_reg, w_data, w_strb);
        clr_bits   = w_data & strb_mask(w_strb);
        edge_set   = sw_stable & ~sw_stable_d;
        edge_clr   = (commit && aw_word == REG_EDGE) ? clr_bits[NUM_SW-1:0] : '0;

        rd_mux = '0;
        case (reg_word_e'(S_AXI_ARADDR[3:2]))
            REG_LED:       rd_mux = 32'(led_reg);
            REG_SW_STATUS: rd_mux = 32'(sw_stable);
            REG_EDGE:      rd_mux = 32'(edge_reg);
            REG_AUX:       rd_mux = aux_reg;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_word      <= REG_LED;
            w_data       <= '0;
            w_strb       <= '0;
            S_AXI_BVALID <= 1'b0;
            led_reg      <= '0;
            edge_reg     <= '0;
            sw_stable_d  <= '0;
            aux_reg      <= '0;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held <= 1'b1;
                aw_word <= reg_word_e'(S_AXI_AWADDR[3:2]);
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end

            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                case (aw_word)
                    REG_LED: led_reg <= led_merged[NUM_SW-1:0];
                    REG_AUX: aux_reg <= aux_merged;
                    default: ;
                endcase
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            // A new rising edge beats a simultaneous W1C of the same bit.
            edge_reg    <= (edge_reg & ~edge_clr) | edge_set;
            sw_stable_d <= sw_stable;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
        end else begin
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

`ifdef SWITCH_IRQ_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_reg & aux_reg[NUM_SW-1:0]);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_axil_slave.sv
// ============================================================================
// Module      : tb_switch_axil_slave
// Description : Scoreboard bench for switch_axil_slave (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_axil_slave;

    localparam int NUM_SW = 8;
    localparam int DEB    = 16;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [NUM_SW-1:0] sw_in;
    logic [NUM_SW-1:0] led_out;
`ifdef SWITCH_IRQ_EN
    logic        irq;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] rq[$];
    logic [1:0]  bq[$];

    switch_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_SW             (NUM_SW),
        .DEBOUNCE_CYCLES    (DEB)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .sw_in         (sw_in),
        .led_out       (led_out)
`ifdef SWITCH_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Monitor: pops expected responses whenever a channel handshake is about to occur.
    initial begin
        logic [31:0] exp_r;
        logic [1:0]  exp_b;
        forever begin
            @(negedge ACLK);
            if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
                if (rq.size() == 0) begin
                    timeout_fail("unexpected_rvalid");
                end else begin
                    exp_r = rq.pop_front();
                    check("rdata", S_AXI_RDATA, exp_r);
                    check("rresp", {30'b0, S_AXI_RRESP}, 32'h0);
                end
            end
            if (!ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
                if (bq.size() == 0) begin
                    timeout_fail("unexpected_bvalid");
                end else begin
                    exp_b = bq.pop_front();
                    check("bresp", {30'b0, S_AXI_BRESP}, {30'b0, exp_b});
                end
            end
        end
    end

    // All drive tasks start and end #1 after a rising edge.
    task automatic wait_b();
        int n = 0;
        while (!(S_AXI_BVALID && S_AXI_BREADY) && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (!(S_AXI_BVALID && S_AXI_BREADY)) timeout_fail("bvalid_wait");
        @(posedge ACLK); #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_hs;
        bit w_hs;
        int n = 0;
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        bq.push_back(2'b00);
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 50) begin
            @(negedge ACLK);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
            n++;
        end
        if (S_AXI_AWVALID || S_AXI_WVALID) begin
            timeout_fail("aw_w_accept");
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
        end
        wait_b();
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
        bit hs = 1'b0;
        int n = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        rq.push_back(exp);
        while (!hs && n < 50) begin
            @(negedge ACLK);
            hs = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!hs) timeout_fail("ar_accept");
        n = 0;
        while (!S_AXI_RVALID && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (!S_AXI_RVALID) timeout_fail("rvalid_wait");
        @(posedge ACLK); #1;
    endtask

    initial begin
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA  = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        sw_in = '0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        check("rst_awready", {31'b0, S_AXI_AWREADY}, 32'h1);
        check("rst_wready",  {31'b0, S_AXI_WREADY},  32'h1);
        check("rst_arready", {31'b0, S_AXI_ARREADY}, 32'h1);
        check("rst_bvalid",  {31'b0, S_AXI_BVALID},  32'h0);
        check("rst_rvalid",  {31'b0, S_AXI_RVALID},  32'h0);
        check("rst_rdata",   S_AXI_RDATA,            32'h0);
        check("rst_led_out", {24'b0, led_out},       32'h0);
`ifdef SWITCH_IRQ_EN
        check("rst_irq",     {31'b0, irq},           32'h0);
`endif
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'h0);

        // LED register with full strobe; upper bits do not exist.
        axi_write(4'h0, 32'h0101FFFF, 4'hF);
        axi_read(4'h0, 32'h000000FF);
        check("led_out_ff", {24'b0, led_out}, 32'hFF);

        // Scratch byte strobes.
        axi_write(4'hC, 32'hABCD0001, 4'h3);
        axi_read(4'hC, 32'h00000001);
        axi_write(4'hC, 32'h12345678, 4'hC);
        axi_read(4'hC, 32'h12340001);

        // Writes that must not change state.
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
        axi_read(4'h4, 32'h0);
        axi_write(4'h0, 32'h00000000, 4'h0);
        axi_read(4'h0, 32'h000000FF);
        axi_write(4'h0, 32'h12345A5A, 4'h2);
        axi_read(4'h0, 32'h000000FF);
        axi_write(4'h0, 32'h0000005A, 4'h1);
        check("led_out_5a", {24'b0, led_out}, 32'h5A);

        // AW three cycles ahead of W, with BREADY held low.
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = 4'h0;
        S_AXI_AWVALID = 1'b1;
        bq.push_back(2'b00);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        check("aw_held_awready", {31'b0, S_AXI_AWREADY}, 32'h0);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        S_AXI_WDATA  = 32'h0000003C;
        S_AXI_WSTRB  = 4'h1;
        S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        check("bvalid_at_w_hs", {31'b0, S_AXI_BVALID}, 32'h0);
        @(posedge ACLK); #1;
        check("bvalid_next", {31'b0, S_AXI_BVALID}, 32'h1);
        check("led_out_3c", {24'b0, led_out}, 32'h3C);
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            check("bvalid_hold", {30'b0, S_AXI_BVALID, S_AXI_AWREADY}, 32'h2);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        check("bvalid_clear", {30'b0, S_AXI_BVALID, S_AXI_AWREADY}, 32'h1);
        axi_read(4'h0, 32'h0000003C);

        // 5-cycle glitch on switch 3 must not propagate.
        sw_in[3] = 1'b1;
        repeat (5) @(posedge ACLK);
        #1 sw_in[3] = 1'b0;
        repeat (30) @(posedge ACLK);
        #1;
        axi_read(4'h4, 32'h0);
        axi_read(4'h8, 32'h0);

        // Clean step: status still 0 for a read accepted 18 edges later, 1 after.
        sw_in[3] = 1'b1;
        repeat (17) @(posedge ACLK);
        #1;
        axi_read(4'h4, 32'h00);
        axi_read(4'h4, 32'h08);
        axi_read(4'h8, 32'h08);
`ifdef SWITCH_IRQ_EN
        check("irq_unmasked", {31'b0, irq}, 32'h0);
        axi_write(4'hC, 32'h00000008, 4'hF);
        check("irq_set", {31'b0, irq}, 32'h1);
`endif
        axi_write(4'h8, 32'h00000008, 4'h0);
        axi_read(4'h8, 32'h08);
        axi_write(4'h8, 32'h00000008, 4'h1);
`ifdef SWITCH_IRQ_EN
        check("irq_clear", {31'b0, irq}, 32'h0);
`endif
        axi_read(4'h8, 32'h00);

        // Switch 0 rises on the same edge that commits a W1C of bit 0.
        sw_in[0] = 1'b1;
        repeat (17) @(posedge ACLK);
        #1;
        axi_write(4'h8, 32'h00000001, 4'hF);
        axi_read(4'h8, 32'h01);

        // A read of EDGE on the commit edge sees the pre-commit value.
        fork
            axi_write(4'h8, 32'h00000001, 4'hF);
            begin
                @(posedge ACLK); #1;
                axi_read(4'h8, 32'h01);
            end
        join
        axi_read(4'h8, 32'h00);

        // Falling edges never set EDGE.
        sw_in[0] = 1'b0;
        repeat (25) @(posedge ACLK);
        #1;
        axi_read(4'h4, 32'h08);
        axi_read(4'h8, 32'h00);

        // Reset during an outstanding read and a held write address.
        S_AXI_RREADY  = 1'b0;
        S_AXI_ARADDR  = 4'h0;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = 4'h0;
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        check("pre_rst_rvalid",  {31'b0, S_AXI_RVALID},  32'h1);
        check("pre_rst_awready", {31'b0, S_AXI_AWREADY}, 32'h0);
        #2 ARESET = 1'b1;
        #1;
        check("mid_rst_rvalid",  {31'b0, S_AXI_RVALID},  32'h0);
        check("mid_rst_awready", {31'b0, S_AXI_AWREADY}, 32'h1);
        check("mid_rst_led_out", {24'b0, led_out},       32'h0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        S_AXI_RREADY = 1'b1;
        axi_read(4'h0, 32'h0);
        axi_read(4'h4, 32'h0);

        repeat (5) @(posedge ACLK);
        if (rq.size() != 0 || bq.size() != 0) timeout_fail("scoreboard_drain");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
